// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, load extraction/extension and fault decode.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_fault,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic        w_legal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Legal funct3 set depends on direction; size alignment from funct3[1:0]
  always_comb begin
    w_legal = 1'b0;
    if (i_is_store) begin
      case (i_funct3)
        F3_B, F3_H, F3_W: w_legal = 1'b1;
        default:          w_legal = 1'b0;
      endcase
    end else if (i_is_load) begin
      case (i_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_legal = 1'b1;
        default:                        w_legal = 1'b0;
      endcase
    end
    o_fault = (i_is_store | i_is_load) &
              (~w_legal |
               ((i_funct3[1:0] == 2'b01) & i_off[0]) |
               ((i_funct3[1:0] == 2'b10) & (i_off != 2'b00)));
  end

  // Store lane replication and byte enables
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage load/store unit: bus handshake, timeout and pipeline stall.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       WriteDataM,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        funct3M,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              misaligned,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_bus_err;
  logic [2:0]          r_f3;
  logic [1:0]          r_off;

  logic                w_store;
  logic                w_load;
  logic                w_fault;
  logic                w_start;
  logic                w_timeout;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rdata_ext;

  assign w_store = MemWriteM;
  assign w_load  = (ResultSrcM == RESULT_SRC_MEM) & ~MemWriteM;

  mem_lane_align u_align (
    .i_is_load   (w_load),
    .i_is_store  (w_store),
    .i_funct3    (funct3M),
    .i_off       (ALUResultM[1:0]),
    .i_wdata     (WriteDataM),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_fault     (w_fault),
    .i_ld_funct3 (r_f3),
    .i_ld_off    (r_off),
    .i_rdata     (mem_rdata),
    .o_rdata     (w_rdata_ext)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode plus combinational stall/fault outputs
  always_comb begin
    w_state_next = r_state;
    StallM       = 1'b0;
    misaligned   = 1'b0;
    w_start      = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_store | w_load) begin
          if (w_fault) begin
            misaligned = 1'b1;
          end else begin
            StallM       = 1'b1;
            w_start      = 1'b1;
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (mem_ready) begin
          w_state_next = DONE;
        end else if (r_cnt == CNT_MAX) begin
          w_timeout    = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bus registers, wait counter, load result and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_bus_err <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= w_store;
            r_addr  <= {ALUResultM[ADDR_W-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_f3    <= funct3M;
            r_off   <= ALUResultM[1:0];
          end else if (misaligned) begin
            r_rdata <= '0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (!r_we) r_rdata <= w_rdata_ext;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_bus_err <= 1'b1;
            r_rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign ReadDataM = r_rdata;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

endmodule
